// File: rtl/multi_axi_bridge_pkg.sv
// Shared bus definitions for multi_axi_bridge: AXI3 field widths, fixed
// field values used for single-beat transfers, and the FSM state encoding.
package multi_axi_bridge_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = '0;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_LOCK_W-1:0]  AXI_LOCK_NORM  = 2'b00;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_DEF  = 4'b0000;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT_DEF   = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } bridge_state_e;

  // AxSIZE encoding for a beat of the given byte count
  function automatic logic [AXI_SIZE_W-1:0] axi_size(input int bytes);
    axi_size = '0;
    for (int k = 0; k < 8; k++) begin
      if ((1 << k) == bytes) axi_size = AXI_SIZE_W'(k);
    end
  endfunction

endpackage

// File: rtl/multi_axi_bridge_arbiter.sv
// bridge_arbiter: pending vector in, one-hot grant out. BRIDGE_RR_ARB_EN selects
// round-robin (pointer holds the next search start); otherwise lowest index wins.
module bridge_arbiter #(
  parameter int CH_NUM = 2
) (
`ifdef BRIDGE_RR_ARB_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              take,
`endif
  input  logic [CH_NUM-1:0] pending,
  output logic [CH_NUM-1:0] grant
);

`ifdef BRIDGE_RR_ARB_EN
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [2*CH_NUM-1:0] pend_dbl, grant_dbl;
  logic [CH_NUM-1:0]   pend_rot, grant_rot;
  int                  nxt;

  // Rotate so bit 0 is the search start, pick lowest, rotate back
  always_comb begin
    pend_dbl  = {pending, pending} >> ptr_q;
    pend_rot  = pend_dbl[CH_NUM-1:0];
    grant_rot = '0;
    nxt       = 0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        grant_rot    = '0;
        grant_rot[k] = 1'b1;
        nxt          = int'(ptr_q) + k + 1;
      end
    end
    if (nxt >= CH_NUM) nxt = nxt - CH_NUM;
    grant_dbl = {grant_rot, grant_rot} << ptr_q;
    grant     = grant_dbl[2*CH_NUM-1:CH_NUM];
    ptr_d     = ptr_q;
    if (take) ptr_d = PTR_W'(nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (pending[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/multi_axi_bridge.sv
// multi_axi_bridge: CH_NUM SRAM-style clients onto one AXI3 master, one
// single-beat transaction in flight. Define BRIDGE_RR_ARB_EN for round-robin.
//   state    | meaning
//   ST_IDLE  | wait for a pending slot, grant one channel
//   ST_RADDR | arvalid held until arready
//   ST_RDATA | rready held until rvalid, result latched
//   ST_WADDR | aw and w channels, each dropped on its own handshake
//   ST_WRESP | bready held until bvalid
module multi_axi_bridge
  import multi_axi_bridge_pkg::*;
#(
  parameter int CH_NUM     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CH_NUM-1:0]                sram_en,
  input  logic [CH_NUM*DATA_WIDTH/8-1:0]   sram_write_en,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     sram_addr,
  input  logic [CH_NUM*DATA_WIDTH-1:0]     sram_write_data,
  output logic [CH_NUM*DATA_WIDTH-1:0]     sram_read_data,
  output logic [CH_NUM-1:0]                sram_ready,
  output logic [ID_WIDTH-1:0]              arid,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic [AXI_LEN_W-1:0]             arlen,
  output logic [AXI_SIZE_W-1:0]            arsize,
  output logic [AXI_BURST_W-1:0]           arburst,
  output logic [AXI_LOCK_W-1:0]            arlock,
  output logic [AXI_CACHE_W-1:0]           arcache,
  output logic [AXI_PROT_W-1:0]            arprot,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [ID_WIDTH-1:0]              rid,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [AXI_RESP_W-1:0]            rresp,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready,
  output logic [ID_WIDTH-1:0]              awid,
  output logic [ADDR_WIDTH-1:0]            awaddr,
  output logic [AXI_LEN_W-1:0]             awlen,
  output logic [AXI_SIZE_W-1:0]            awsize,
  output logic [AXI_BURST_W-1:0]           awburst,
  output logic [AXI_LOCK_W-1:0]            awlock,
  output logic [AXI_CACHE_W-1:0]           awcache,
  output logic [AXI_PROT_W-1:0]            awprot,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [ID_WIDTH-1:0]              wid,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH/8-1:0]          wstrb,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [ID_WIDTH-1:0]              bid,
  input  logic [AXI_RESP_W-1:0]            bresp,
  input  logic                             bvalid,
  output logic                             bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_VAL = axi_size(STRB_W);

  bridge_state_e   state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d, gnt_idx;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            aw_fin, w_fin, rd_done, wr_done;

  logic [CH_NUM-1:0]     pend_q, pend_d, rdy_q, rdy_d, grant;
  logic [ADDR_WIDTH-1:0] addr_q [CH_NUM];
  logic [ADDR_WIDTH-1:0] addr_d [CH_NUM];
  logic [DATA_WIDTH-1:0] wdat_q [CH_NUM];
  logic [DATA_WIDTH-1:0] wdat_d [CH_NUM];
  logic [STRB_W-1:0]     strb_q [CH_NUM];
  logic [STRB_W-1:0]     strb_d [CH_NUM];
  logic [DATA_WIDTH-1:0] rdat_q [CH_NUM];
  logic [DATA_WIDTH-1:0] rdat_d [CH_NUM];

  // Response IDs and codes carry nothing the bridge acts on
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

`ifdef BRIDGE_RR_ARB_EN
  logic arb_take;
  assign arb_take = (state_q == ST_IDLE) && (|pend_q);

  bridge_arbiter #(.CH_NUM(CH_NUM)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .take    (arb_take),
    .pending (pend_q),
    .grant   (grant)
  );
`else
  bridge_arbiter #(.CH_NUM(CH_NUM)) u_arb (
    .pending (pend_q),
    .grant   (grant)
  );
`endif

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (grant[k]) gnt_idx = CH_W'(k);
    end
  end

  assign rd_done = (state_q == ST_RDATA) && rvalid;
  assign wr_done = (state_q == ST_WRESP) && bvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          gnt_d     = gnt_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|strb_q[gnt_idx]) ? ST_WADDR : ST_RADDR;
        end
      end
      ST_RADDR: if (arready) state_d = ST_RDATA;
      ST_RDATA: if (rvalid)  state_d = ST_IDLE;
      ST_WADDR: begin
        aw_fin    = aw_done_q || awready;
        w_fin     = w_done_q  || wready;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = ST_WRESP;
      end
      ST_WRESP: if (bvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_q)
      ST_RADDR: arvalid = 1'b1;
      ST_RDATA: rready  = 1'b1;
      ST_WADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      ST_WRESP: bready  = 1'b1;
      default: ;
    endcase
  end

  assign arid    = ID_WIDTH'(gnt_q);
  assign araddr  = addr_q[gnt_q];
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_VAL;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORM;
  assign arcache = AXI_CACHE_DEF;
  assign arprot  = AXI_PROT_DEF;
  assign awid    = ID_WIDTH'(gnt_q);
  assign awaddr  = addr_q[gnt_q];
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_VAL;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORM;
  assign awcache = AXI_CACHE_DEF;
  assign awprot  = AXI_PROT_DEF;
  assign wid     = ID_WIDTH'(gnt_q);
  assign wdata   = wdat_q[gnt_q];
  assign wstrb   = strb_q[gnt_q];
  assign wlast   = wvalid;

  // Capture only while ready; completion can never hit a channel that is capturing
  always_comb begin
    pend_d = pend_q;
    rdy_d  = rdy_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    strb_d = strb_q;
    rdat_d = rdat_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (sram_en[i] && rdy_q[i]) begin
        pend_d[i] = 1'b1;
        rdy_d[i]  = 1'b0;
        addr_d[i] = sram_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdat_d[i] = sram_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        strb_d[i] = sram_write_en[i*STRB_W +: STRB_W];
      end
    end
    if (rd_done) begin
      pend_d[gnt_q] = 1'b0;
      rdy_d[gnt_q]  = 1'b1;
      rdat_d[gnt_q] = rdata;
    end
    if (wr_done) begin
      pend_d[gnt_q] = 1'b0;
      rdy_d[gnt_q]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      rdy_q  <= '1;
      for (int i = 0; i < CH_NUM; i++) begin
        addr_q[i] <= '0;
        wdat_q[i] <= '0;
        strb_q[i] <= '0;
        rdat_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      strb_q <= strb_d;
      rdat_q <= rdat_d;
    end
  end

  assign sram_ready = rdy_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_rdat
    assign sram_read_data[g*DATA_WIDTH +: DATA_WIDTH] = rdat_q[g];
  end

endmodule
